// File: rtl/song_reader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | song_reader_pkg : shared sizes, FSM encoding and song table  r1.0   |
// +--------------------------------------------------------------------+
package song_reader_pkg;

  localparam int IDX_W  = 5;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  localparam logic [DUR_W-1:0] END_DUR = '0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_ROM  = 3'd2,
    WAIT_NOTE = 3'd3,
    END       = 3'd4
  } state_t;

  // Built-in song table, packed as {pitch, duration}; duration 0 ends a song.
  function automatic logic [NOTE_W+DUR_W-1:0] song_word(input int song, input int idx);
    logic [NOTE_W-1:0] n;
    logic [DUR_W-1:0]  d;
    n = '0;
    d = END_DUR;
    case (song)
      0: case (idx)
           0: begin n = 6'd12; d = 6'd8; end
           1: begin n = 6'd20; d = 6'd3; end
           2: begin n = 6'd7;  d = 6'd5; end
           default: ;
         endcase
      1: case (idx)
           0: begin n = 6'd30; d = 6'd2; end
           1: begin n = 6'd0;  d = 6'd4; end
           2: begin n = 6'd45; d = 6'd1; end
           default: ;
         endcase
      2: begin
           n = NOTE_W'(idx + 1);
           d = DUR_W'((idx % 7) + 1);
         end
      3: case (idx)
           0: begin n = 6'd33; d = 6'd9; end
           1: begin n = 6'd17; d = 6'd6; end
           default: ;
         endcase
      default: ;
    endcase
    return {n, d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/song_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | song_reader_if : control-FSM / note-player side bundle       r1.0   |
// +--------------------------------------------------------------------+
interface song_reader_if #(
  parameter int NOTE_W = song_reader_pkg::NOTE_W,
  parameter int DUR_W  = song_reader_pkg::DUR_W
);
  logic              play;
  logic [1:0]        song;
  logic              reset_play;
  logic              note_done;
  logic              new_note;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;
  logic              song_done;

  modport master (
    output play, song, reset_play, note_done,
    input  new_note, note, duration, song_done
  );

  modport slave (
    input  play, song, reset_play, note_done,
    output new_note, note, duration, song_done
  );
endinterface
`default_nettype wire

// File: rtl/song_reader_rom.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | song_rom : 4-song note table, registered output, 1-cycle read r1.0 |
// +--------------------------------------------------------------------+
module song_rom #(
  parameter int IDX_W  = song_reader_pkg::IDX_W,
  parameter int NOTE_W = song_reader_pkg::NOTE_W,
  parameter int DUR_W  = song_reader_pkg::DUR_W
) (
  input  wire logic                    clk,
  input  wire logic [IDX_W+1:0]        addr,
  output      logic [NOTE_W+DUR_W-1:0] data
);
  import song_reader_pkg::*;

  always_ff @(posedge clk) begin
    data <= (NOTE_W+DUR_W)'(song_word(int'(addr[IDX_W+1:IDX_W]), int'(addr[IDX_W-1:0])));
  end
endmodule
`default_nettype wire

// File: rtl/song_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | song_reader : walks a song's note table, hands notes to player r1.0 |
// | SONG_LOOP_EN : restart the song after song_done instead of parking  |
// +--------------------------------------------------------------------+
module song_reader #(
  parameter int IDX_W  = song_reader_pkg::IDX_W,
  parameter int NOTE_W = song_reader_pkg::NOTE_W,
  parameter int DUR_W  = song_reader_pkg::DUR_W
) (
  input wire logic   clk,
  input wire logic   reset,
  song_reader_if.slave bus
);
  import song_reader_pkg::*;

`ifdef SONG_LOOP_EN
  localparam state_t AFTER_END = IDLE;
  localparam bit     LOOP      = 1'b1;
`else
  localparam state_t AFTER_END = END;
  localparam bit     LOOP      = 1'b0;
`endif

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W+1:0]          rom_addr;
  logic [NOTE_W+DUR_W-1:0]   rom_data;
  logic [NOTE_W-1:0]         rom_note;
  logic [DUR_W-1:0]          rom_dur;

  // song is part of the address, so a song change lands on the next fetch
  assign rom_addr = {bus.song, idx};
  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  song_rom #(.IDX_W(IDX_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      bus.new_note  <= 1'b0;
      bus.song_done <= 1'b0;
      bus.note      <= '0;
      bus.duration  <= '0;
    end else if (bus.reset_play) begin
      state         <= IDLE;
      idx           <= '0;
      bus.new_note  <= 1'b0;
      bus.song_done <= 1'b0;
    end else begin
      bus.new_note  <= 1'b0;
      bus.song_done <= 1'b0;
      case (state)
        IDLE: if (bus.play) state <= FETCH;
        FETCH: state <= WAIT_ROM;
        WAIT_ROM: begin
          if (rom_dur == END_DUR) begin
            bus.song_done <= 1'b1;
            state         <= AFTER_END;
            if (LOOP) idx <= '0;
          end else begin
            bus.note     <= rom_note;
            bus.duration <= rom_dur;
            bus.new_note <= 1'b1;
            state        <= WAIT_NOTE;
          end
        end
        WAIT_NOTE: begin
          if (bus.note_done) begin
            // last slot of the region: end here rather than wrap into the next song
            if (idx == '1) begin
              bus.song_done <= 1'b1;
              state         <= AFTER_END;
              if (LOOP) idx <= '0;
            end else begin
              idx   <= idx + 1'b1;
              state <= IDLE;
            end
          end
        end
        END: state <= END;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_song_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_song_reader : self-checking bench for song_reader          r1.0 |
// +--------------------------------------------------------------------+
module tb_song_reader;
  import song_reader_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   region_err = 0;

  always #5 clk = ~clk;

  song_reader_if bus ();

  song_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int song;
    int first_note;
    int first_dur;
    int n_notes;
  } vec_t;

  // A fetch must always address the region of the currently selected song.
  always @(negedge clk) begin
    if (!reset && dut.state == FETCH && dut.rom_addr[IDX_W+1:IDX_W] != bus.song)
      region_err++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: sim time exceeded, want finish");
    $fatal(1, "timeout");
  end

  // Reference songs as plain note lists.
  function automatic int ref_pitch(input int s, input int i);
    int p0[3] = '{12, 20, 7};
    int p1[3] = '{30, 0, 45};
    int p3[2] = '{33, 17};
    case (s)
      0: return (i < 3) ? p0[i] : 0;
      1: return (i < 3) ? p1[i] : 0;
      2: return (i < 32) ? i + 1 : 0;
      default: return (i < 2) ? p3[i] : 0;
    endcase
  endfunction

  function automatic int ref_dur(input int s, input int i);
    int d0[3] = '{8, 3, 5};
    int d1[3] = '{2, 4, 1};
    int d3[2] = '{9, 6};
    case (s)
      0: return (i < 3) ? d0[i] : 0;
      1: return (i < 3) ? d1[i] : 0;
      2: return (i < 32) ? (i % 7) + 1 : 0;
      default: return (i < 2) ? d3[i] : 0;
    endcase
  endfunction

  function automatic int ref_len(input int s);
    int n = 0;
    while (n < 32 && ref_dur(s, n) != 0) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic pulse_reset_play();
    bus.reset_play = 1'b1;
    tick();
    bus.reset_play = 1'b0;
  endtask

  task automatic wait_note(input string name);
    int w = 0;
    while (!bus.new_note && w < 40) begin
      tick();
      w++;
    end
    check(name, 32'(bus.new_note), 1);
  endtask

  task automatic play_song(input int s, input bit rnd, output int notes, output int dones);
    int  k = 0;
    int  w;
    int  gap;
    int  quiet;
    bit  ended = 1'b0;
    notes = 0;
    dones = 0;
    bus.song = 2'(s);
    bus.play = 1'b1;
    while (!ended) begin
      w = 0;
      while (!bus.new_note && !bus.song_done && w < 60) begin
        tick();
        w++;
      end
      if (w >= 60) begin
        check("song_timeout", 32'(bus.new_note | bus.song_done), 1);
        ended = 1'b1;
      end else if (bus.song_done) begin
        dones++;
        check("end_index", k, ref_len(s));
        tick();
        check("done_width", 32'(bus.song_done), 0);
`ifdef SONG_LOOP_EN
        w = 0;
        while (!bus.new_note && w < 60) begin
          tick();
          w++;
        end
        check("loop_replay", 32'(bus.new_note), 1);
        check("loop_note", 32'(bus.note), ref_pitch(s, 0));
        check("loop_dur", 32'(bus.duration), ref_dur(s, 0));
`else
        quiet = 0;
        repeat (10) begin
          tick();
          if (bus.new_note || bus.song_done) quiet++;
        end
        check("end_quiet", quiet, 0);
`endif
        ended = 1'b1;
      end else begin
        check("note", 32'(bus.note), ref_pitch(s, k));
        check("duration", 32'(bus.duration), ref_dur(s, k));
        k++;
        notes++;
        gap = rnd ? int'($urandom_range(1, 6)) : 5;
        if (rnd && $urandom_range(0, 1) == 1) bus.play = 1'b0;
        repeat (gap - 1) tick();
        bus.note_done = 1'b1;
        tick();
        bus.note_done = 1'b0;
        if (!bus.play && !bus.song_done) begin
          quiet = 0;
          repeat ($urandom_range(2, 12)) begin
            tick();
            if (bus.new_note) quiet++;
          end
          check("pause_hold", quiet, 0);
        end
        bus.play = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t vecs[4];
    int   quiet;
    int   n_notes;
    int   n_dones;
    int   s;

    vecs[0] = '{song: 0, first_note: 12, first_dur: 8, n_notes: 3};
    vecs[1] = '{song: 1, first_note: 30, first_dur: 2, n_notes: 3};
    vecs[2] = '{song: 2, first_note: 1,  first_dur: 1, n_notes: 32};
    vecs[3] = '{song: 3, first_note: 33, first_dur: 9, n_notes: 2};

    bus.play       = 1'b0;
    bus.song       = 2'd0;
    bus.reset_play = 1'b0;
    bus.note_done  = 1'b0;
    reset          = 1'b1;
    repeat (3) tick();
    check("rst_new_note", 32'(bus.new_note), 0);
    check("rst_note", 32'(bus.note), 0);
    check("rst_duration", 32'(bus.duration), 0);
    check("rst_song_done", 32'(bus.song_done), 0);
    check("rst_idx", 32'(dut.idx), 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;

    // play sampled at the next edge; new_note three edges later
    bus.play = 1'b1;
    tick();
    check("lat_c1", 32'(bus.new_note), 0);
    tick();
    check("lat_c2", 32'(bus.new_note), 0);
    tick();
    check("lat_new_note", 32'(bus.new_note), 1);
    check("lat_note", 32'(bus.note), 12);
    check("lat_duration", 32'(bus.duration), 8);
    check("lat_song_done", 32'(bus.song_done), 0);

    // pause: note still retired, nothing issued until play returns
    bus.play = 1'b0;
    tick();
    check("pulse_width", 32'(bus.new_note), 0);
    repeat (3) tick();
    bus.note_done = 1'b1;
    tick();
    bus.note_done = 1'b0;
    quiet = 0;
    repeat (20) begin
      tick();
      if (bus.new_note) quiet++;
    end
    check("pause_quiet", quiet, 0);
    check("pause_note_held", 32'(bus.note), 12);
    bus.play = 1'b1;
    tick();
    tick();
    check("resume_c2", 32'(bus.new_note), 0);
    tick();
    check("resume_new_note", 32'(bus.new_note), 1);
    check("resume_note", 32'(bus.note), 20);
    check("resume_duration", 32'(bus.duration), 3);

    // reset_play coincident with note_done at idx 4 of song 2
    pulse_reset_play();
    bus.song = 2'd2;
    for (int k = 0; k < 5; k++) begin
      wait_note("rp_wait");
      check("rp_note", 32'(bus.note), k + 1);
      if (k < 4) begin
        tick();
        tick();
        bus.note_done = 1'b1;
        tick();
        bus.note_done = 1'b0;
      end
    end
    check("rp_idx4", 32'(dut.idx), 4);
    bus.note_done  = 1'b1;
    bus.reset_play = 1'b1;
    tick();
    bus.note_done  = 1'b0;
    bus.reset_play = 1'b0;
    check("rp_idx_zero", 32'(dut.idx), 0);
    tick();
    tick();
    check("rp_hold_nn", 32'(bus.new_note), 0);
    check("rp_hold_note", 32'(bus.note), 5);
    check("rp_hold_dur", 32'(bus.duration), 5);
    tick();
    check("rp_restart_nn", 32'(bus.new_note), 1);
    check("rp_restart_note", 32'(bus.note), 1);
    check("rp_restart_dur", 32'(bus.duration), 1);

    // whole songs from a fixed vector table
    for (int v = 0; v < 4; v++) begin
      pulse_reset_play();
      bus.song = 2'(vecs[v].song);
      bus.play = 1'b1;
      wait_note("tbl_first_wait");
      check("tbl_first_note", 32'(bus.note), vecs[v].first_note);
      check("tbl_first_dur", 32'(bus.duration), vecs[v].first_dur);
      pulse_reset_play();
      play_song(vecs[v].song, 1'b0, n_notes, n_dones);
      check("tbl_note_count", n_notes, vecs[v].n_notes);
      check("tbl_done_count", n_dones, 1);
    end

    // randomized songs, note_done delays and pauses
    for (int r = 0; r < 8; r++) begin
      s = int'($urandom_range(0, 3));
      pulse_reset_play();
      play_song(s, 1'b1, n_notes, n_dones);
      check("rnd_note_count", n_notes, ref_len(s));
      check("rnd_done_count", n_dones, 1);
    end

    check("fetch_region", region_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
